// File: rtl/mem_arb_pkg.sv
// Shared types for the Memoria port arbiter: FSM states, owner encoding, access direction.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational owner pick: data wins unless fetch has waited MAX_STREAK data grants.
// Zero latency; no backpressure of its own, the caller samples it only when idle.
module arb_priority_sel
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic streak_max,
  output logic grant_vld,
  output logic grant_owner
);

  always_comb begin
    grant_vld   = if_req | dm_req;
    grant_owner = (dm_req && !(if_req && streak_max)) ? OWN_DM : OWN_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the Memoria port between fetch and load/store; one access per MEM_LAT+2 cycles.
// Requests are sampled only in IDLE; ack is a one-cycle pulse MEM_LAT+1 cycles after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_vld;
  logic              grant_owner;

  arb_priority_sel u_sel (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .streak_max  (streak_q == STK_MAX),
    .grant_vld   (grant_vld),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d  = ST_BUSY;
          owner_d  = grant_owner;
          cnt_d    = CNT_INIT;
          mem_en_d = 1'b1;
          if (grant_owner == OWN_DM) begin
            mem_rw_d    = dm_we ? MEM_WR : MEM_RD;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            // Saturate while fetch is kept waiting; a fetch-free data grant clears it.
            if (!if_req)
              streak_d = '0;
            else if (streak_q != STK_MAX)
              streak_d = streak_q + STK_W'(1);
          end else begin
            mem_rw_d   = MEM_RD;
            mem_addr_d = if_addr;
            streak_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (owner_q == OWN_IF)
            if_rdata_d = mem_rdata;
          else if (mem_rw_q == MEM_RD)
            dm_rdata_d = mem_rdata;
          if_ack_d = (owner_q == OWN_IF);
          dm_ack_d = (owner_q == OWN_DM);
          mem_en_d = 1'b0;
          mem_rw_d = MEM_RD;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= MEM_RD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule
